link_frame_arbiter: RTL and testbench
=====================================

Name: link_frame_arbiter

Overview:
- Shares the single S1→S2 serial link (sen/sd) between two frame requesters, e.g. the RB1 read-back path and a second source.
- Each requester presents a complete frame: {3-bit RB2 address, 18-bit data}, 21 bits. The block grants one requester round-robin, then serializes its frame MSB-first with the same sen/sd framing that S2 already decodes.
- Counts completed frames and raises done after MAX_FRAMES frames.

Parameters:
- ADDR_W, 3, RB2 address field width.
- DATA_W, 18, RB2 data field width.
- GAP, 1, exact number of idle cycles (sen=1) between back-to-back frames; must be at least 1.
- MAX_FRAMES, 8, completed frames before done asserts.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- req0  input  1  requester 0 has a frame pending.
- frame0  input  21  requester 0 frame, [20:18]=addr, [17:0]=data.
- gnt0  output  1  one-cycle pulse: frame0 was captured.
- req1  input  1  requester 1 has a frame pending.
- frame1  input  21  requester 1 frame.
- gnt1  output  1  one-cycle pulse: frame1 was captured.
- sen  output  1  0 = frame bit valid on sd; 1 = idle.
- sd  output  1  serial data, MSB (bit 20) first.
- busy  output  1  state is not IDLE.
- frames_sent  output  4  completed-frame count; saturates at MAX_FRAMES.
- done  output  1  sticky; high once frames_sent equals MAX_FRAMES.

Behaviour:
- All outputs are registered.
- Reset (rst=0) is asynchronous and takes effect immediately, including mid-frame. Reset values:
  - sen=1, sd=0, gnt0=gnt1=0, busy=0, frames_sent=0, done=0.
  - state=IDLE; round-robin pointer gives req0 priority.
- States: IDLE, SHIFT, GAP.
- IDLE, no request, or done=1: hold sen=1, sd=0. After done, requests are ignored and no grant is issued.
- IDLE with request and done=0, at the sampling edge:
  - Select the winner.
  - Capture its frame into the shift register.
  - Drive gnt_x=1 for exactly one cycle.
  - Drive sen=0 and sd=frame[20]; load bit counter = 20; go to SHIFT.
  - gnt and the first bit therefore appear together.
- Arbitration:
  - Only one requester active: it wins.
  - Both active: the requester not granted last wins. The first contention after reset goes to req0.
  - The pointer updates on every grant.
- SHIFT: each edge shifts the next bit onto sd, with sen held 0. Exactly 21 consecutive sen=0 cycles, bit 20 down to bit 0.
- Frame end: the edge after bit 0 sets sen=1, sd=0, increments frames_sent, and goes to GAP.
  - done is set on the same edge if the new count equals MAX_FRAMES.
- GAP: hold sen=1 for exactly GAP cycles, then re-evaluate as IDLE on that edge. With a request pending, the next frame's bit 20 follows after exactly GAP idle cycles.
- Requester protocol:
  - Hold req and frame stable until the gnt pulse.
  - The frame is latched at grant; frame_x may change from the cycle gnt_x is high.
  - To send another frame, keep req high after gnt.
  - Dropping req before grant is a protocol violation with undefined result.
- Simultaneous events: a request arriving during SHIFT or GAP waits and is not lost. A reset during SHIFT aborts the frame; an aborted frame is not counted.
- busy = (state != IDLE), registered alongside state.

Decomposition:
- Shared package link_pkg holds:
  - ADDR_W, DATA_W, FRAME_W = ADDR_W + DATA_W.
  - The state enum {IDLE, SHIFT, GAP}.
  - The frame field slice constants. S2-side logic and benches reuse these.
- One sub-module is natural: link_serializer.
  - Contents: 21-bit shift register, 5-bit bit counter, sen/sd drivers.
  - Interface: load pulse plus frame in; last-bit flag out.
  - The arbiter keeps the FSM, round-robin pointer, gap counter, frame counter and done.

Test Plan:
- Reset: hold rst=0 across several edges → sen=1, sd=0, gnt0=gnt1=0, busy=0, frames_sent=0, done=0. Assert rst=0 between edges → outputs change without waiting for clk.
- Single frame: req0 with frame0={3'b010,18'h2A5A5} → gnt0 pulses one cycle with sen falling; 21 sen=0 cycles; sd reassembles 21'h0AA5A5; frames_sent=1; sen=1 afterwards.
- Contention: req0 and req1 held high from reset → frames alternate 0,1,0,1. Exactly GAP=1 sen=1 cycle separates frames. Each gnt is one cycle.
- Latch at grant: change frame0 from 21'h1FFFFF to 21'h000000 in the gnt0 cycle → serialized frame is still 21'h1FFFFF.
- Saturation: send 8 frames → done=1 and frames_sent=8 after the 8th frame's last bit. A 9th req1 gets no gnt1; sen stays 1; done stays 1.
- Mid-frame reset: rst=0 at bit 10 of frame 3 → sen=1 immediately and frames_sent=0. After release, re-request → a complete 21-bit frame is sent and frames_sent=1.

Source files
------------

// File: rtl/link_pkg.sv
// link_pkg: shared definitions for the S1->S2 serial link.
//   ADDR_W / DATA_W / FRAME_W : RB2 frame geometry ({addr, data}).
//   ADDR_* / DATA_* slices    : field positions inside a frame.
//   link_state_e              : arbiter FSM states.
//   rr_pick()                 : round-robin winner selection.
package link_pkg;

  localparam int ADDR_W   = 3;
  localparam int DATA_W   = 18;
  localparam int FRAME_W  = ADDR_W + DATA_W;
  localparam int BITCNT_W = 5;

  // Field slice constants, shared with S2-side decode logic.
  localparam int ADDR_MSB = FRAME_W - 1;
  localparam int ADDR_LSB = DATA_W;
  localparam int DATA_MSB = DATA_W - 1;
  localparam int DATA_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } link_state_e;

  // Returns 1 when requester 1 wins. ptr=1 means requester 1 holds priority.
  function automatic logic rr_pick(input logic req0, input logic req1, input logic ptr);
    logic win1;
    if (req0 && req1) begin
      win1 = ptr;
    end else begin
      win1 = req1;
    end
    return win1;
  endfunction

endpackage

// File: rtl/link_frame_arbiter_if.sv
// link_frame_arbiter_if: requester handshakes and serial link bundle.
//   req0/frame0/gnt0 : requester 0 handshake
//   req1/frame1/gnt1 : requester 1 handshake
//   sen/sd           : serial link (sen=0 marks a valid bit on sd)
//   busy/frames_sent/done : status
// Modports: slave = arbiter side, master = requester / link observer side.
interface link_frame_arbiter_if;
  import link_pkg::*;

  logic               req0;
  logic [FRAME_W-1:0] frame0;
  logic               gnt0;
  logic               req1;
  logic [FRAME_W-1:0] frame1;
  logic               gnt1;
  logic               sen;
  logic               sd;
  logic               busy;
  logic [3:0]         frames_sent;
  logic               done;

  modport slave (
    input  req0, frame0, req1, frame1,
    output gnt0, gnt1, sen, sd, busy, frames_sent, done
  );

  modport master (
    output req0, frame0, req1, frame1,
    input  gnt0, gnt1, sen, sd, busy, frames_sent, done
  );

endinterface

// File: rtl/link_serializer.sv
// link_serializer: shifts one captured frame out MSB-first.
//   clk, rst   : clock, async active-low reset
//   load_s     : capture frame_in and drive its MSB on the next edge
//   frame_in   : frame to send
//   sen, sd    : registered link outputs (sen=0 while a bit is valid)
//   last_bit_s : high while bit 0 is on the link
module link_serializer
  import link_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load_s,
  input  logic [FRAME_W-1:0] frame_in,
  output logic               sen,
  output logic               sd,
  output logic               last_bit_s
);

  logic [FRAME_W-1:0]  shift_r;
  logic [BITCNT_W-1:0] bit_cnt_r;
  logic                sen_r;
  logic                sd_r;

  // Shift register, bit counter and link drivers; sd always mirrors the bit
  // that shift_r will present next, so the MSB goes out on the load edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_r   <= '0;
      bit_cnt_r <= '0;
      sen_r     <= 1'b1;
      sd_r      <= 1'b0;
    end else if (load_s) begin
      shift_r   <= frame_in;
      bit_cnt_r <= BITCNT_W'(FRAME_W - 1);
      sen_r     <= 1'b0;
      sd_r      <= frame_in[FRAME_W-1];
    end else if (!sen_r) begin
      if (bit_cnt_r == '0) begin
        sen_r <= 1'b1;
        sd_r  <= 1'b0;
      end else begin
        shift_r   <= {shift_r[FRAME_W-2:0], 1'b0};
        sd_r      <= shift_r[FRAME_W-2];
        bit_cnt_r <= bit_cnt_r - BITCNT_W'(1);
      end
    end else begin
      sen_r <= 1'b1;
      sd_r  <= 1'b0;
    end
  end

  assign sen        = sen_r;
  assign sd         = sd_r;
  assign last_bit_s = !sen_r && (bit_cnt_r == '0);

endmodule

// File: rtl/link_frame_arbiter.sv
// link_frame_arbiter: round-robin arbiter sharing the S1->S2 link between two
// frame requesters, counting completed frames.
//   clk, rst : clock, async active-low reset
//   bus      : link_frame_arbiter_if.slave (req/frame/gnt x2, sen, sd,
//              busy, frames_sent, done)
// Parameters: GAP (idle cycles between frames, >= 1), MAX_FRAMES.
module link_frame_arbiter
  import link_pkg::*;
#(
  parameter int GAP        = 1,
  parameter int MAX_FRAMES = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  link_frame_arbiter_if.slave  bus
);

  localparam logic [3:0] MAX_CNT  = 4'(MAX_FRAMES);
  localparam logic [7:0] GAP_LAST = 8'(GAP - 1);

  link_state_e state_r, state_nx;
  logic        ptr_r, ptr_nx;
  logic [7:0]  gap_cnt_r, gap_nx;
  logic [3:0]  frames_r, frames_nx;
  logic        done_r, done_nx;
  logic        gnt0_r, gnt0_nx;
  logic        gnt1_r, gnt1_nx;
  logic        busy_r;

  logic               eval_s;
  logic               win1_s;
  logic               load_s;
  logic               last_bit_s;
  logic [FRAME_W-1:0] load_frame_s;
  logic [3:0]         frames_inc_s;

  link_serializer u_ser (
    .clk        (clk),
    .rst        (rst),
    .load_s     (load_s),
    .frame_in   (load_frame_s),
    .sen        (bus.sen),
    .sd         (bus.sd),
    .last_bit_s (last_bit_s)
  );

  // Next-state, arbitration and counter update logic.
  always_comb begin
    state_nx     = state_r;
    ptr_nx       = ptr_r;
    gap_nx       = gap_cnt_r;
    frames_nx    = frames_r;
    done_nx      = done_r;
    gnt0_nx      = 1'b0;
    gnt1_nx      = 1'b0;
    eval_s       = 1'b0;
    win1_s       = 1'b0;
    load_s       = 1'b0;
    frames_inc_s = frames_r + 4'd1;

    case (state_r)
      ST_IDLE: begin
        eval_s = 1'b1;
      end
      ST_SHIFT: begin
        if (last_bit_s) begin
          state_nx = ST_GAP;
          gap_nx   = 8'd0;
          if (frames_r != MAX_CNT) begin
            frames_nx = frames_inc_s;
          end else begin
            frames_nx = frames_r;
          end
          if (frames_inc_s == MAX_CNT) begin
            done_nx = 1'b1;
          end else begin
            done_nx = done_r;
          end
        end else begin
          state_nx = ST_SHIFT;
        end
      end
      ST_GAP: begin
        // The last gap cycle doubles as the IDLE decision so the next bit 20
        // follows after exactly GAP idle cycles.
        if (gap_cnt_r == GAP_LAST) begin
          eval_s = 1'b1;
        end else begin
          gap_nx = gap_cnt_r + 8'd1;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase

    if (eval_s) begin
      if (!done_r && (bus.req0 || bus.req1)) begin
        win1_s   = rr_pick(bus.req0, bus.req1, ptr_r);
        load_s   = 1'b1;
        gnt0_nx  = !win1_s;
        gnt1_nx  = win1_s;
        ptr_nx   = !win1_s;
        state_nx = ST_SHIFT;
      end else begin
        state_nx = ST_IDLE;
      end
    end else begin
      load_s = 1'b0;
    end
  end

  assign load_frame_s = win1_s ? bus.frame1 : bus.frame0;

  // State, pointer, counters and registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      ptr_r     <= 1'b0;
      gap_cnt_r <= 8'd0;
      frames_r  <= 4'd0;
      done_r    <= 1'b0;
      gnt0_r    <= 1'b0;
      gnt1_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_nx;
      ptr_r     <= ptr_nx;
      gap_cnt_r <= gap_nx;
      frames_r  <= frames_nx;
      done_r    <= done_nx;
      gnt0_r    <= gnt0_nx;
      gnt1_r    <= gnt1_nx;
      busy_r    <= (state_nx != ST_IDLE);
    end
  end

  assign bus.gnt0        = gnt0_r;
  assign bus.gnt1        = gnt1_r;
  assign bus.busy        = busy_r;
  assign bus.frames_sent = frames_r;
  assign bus.done        = done_r;

endmodule

// File: tb/tb_link_frame_arbiter.sv
// tb_link_frame_arbiter: directed bench for link_frame_arbiter.
module tb_link_frame_arbiter;
  import link_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  logic swap0_en;
  logic [FRAME_W-1:0] swap0_val;

  link_frame_arbiter_if bus ();

  link_frame_arbiter #(.GAP(1), .MAX_FRAMES(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Receives one frame. Called at a negedge; returns at the first negedge
  // after the frame with sen=1. idle counts sen=1 cycles waited before the
  // first bit (0 means the frame followed the previous gap cycle directly).
  task automatic get_frame(output logic [FRAME_W-1:0] f, output int nbits, output int idle,
                           output logic g0, output logic g1, output logic gstuck);
    int guard;
    f = '0; nbits = 0; idle = 0; guard = 0; gstuck = 1'b0;
    do begin
      @(negedge clk);
      if (bus.sen !== 1'b0) idle++;
      guard++;
    end while (bus.sen !== 1'b0 && guard < 100);
    check("frame_start", {31'd0, bus.sen}, 32'd0);
    g0 = bus.gnt0;
    g1 = bus.gnt1;
    if (swap0_en && bus.gnt0) bus.frame0 = swap0_val;
    while (bus.sen === 1'b0 && nbits < 30) begin
      f = {f[FRAME_W-2:0], bus.sd};
      nbits++;
      @(negedge clk);
      if (nbits == 1) gstuck = bus.gnt0 | bus.gnt1;
    end
  endtask

  logic [FRAME_W-1:0] f;
  int   nb, idl;
  logic g0, g1, gs;
  logic saw_sen0, saw_gnt;
  logic [1:0] order [4];

  initial begin
    n_checks = 0; n_fail = 0;
    swap0_en = 1'b0; swap0_val = '0;
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.frame0 = '0; bus.frame1 = '0;
    rst = 1'b1;
    #1 rst = 1'b0;

    // Reset held over several edges.
    repeat (3) @(negedge clk);
    check("rst_sen",   {31'd0, bus.sen},  32'd1);
    check("rst_sd",    {31'd0, bus.sd},   32'd0);
    check("rst_gnt0",  {31'd0, bus.gnt0}, 32'd0);
    check("rst_gnt1",  {31'd0, bus.gnt1}, 32'd0);
    check("rst_busy",  {31'd0, bus.busy}, 32'd0);
    check("rst_count", {28'd0, bus.frames_sent}, 32'd0);
    check("rst_done",  {31'd0, bus.done}, 32'd0);

    // Single frame from requester 0.
    rst = 1'b1;
    bus.req0 = 1'b1; bus.frame0 = {3'b010, 18'h2A5A5};
    get_frame(f, nb, idl, g0, g1, gs);
    bus.req0 = 1'b0;
    check("single_data",  {11'd0, f}, 32'h000AA5A5);
    check("single_addr",  {29'd0, f[ADDR_MSB:ADDR_LSB]}, 32'd2);
    check("single_field", {14'd0, f[DATA_MSB:DATA_LSB]}, 32'h0002A5A5);
    check("single_bits",  nb, 32'd21);
    check("single_gnt0",  {31'd0, g0}, 32'd1);
    check("single_gnt1",  {31'd0, g1}, 32'd0);
    check("single_gnt_1cyc", {31'd0, gs}, 32'd0);
    check("single_count", {28'd0, bus.frames_sent}, 32'd1);
    check("single_gap_busy", {31'd0, bus.busy}, 32'd1);
    @(negedge clk);
    check("single_idle_sen",  {31'd0, bus.sen},  32'd1);
    check("single_idle_busy", {31'd0, bus.busy}, 32'd0);

    // Contention from reset: alternate 0,1,0,1 with one gap cycle.
    rst = 1'b0;
    @(negedge clk);
    bus.req0 = 1'b1; bus.frame0 = 21'h155555;
    bus.req1 = 1'b1; bus.frame1 = 21'h0ABCDE;
    @(negedge clk);
    rst = 1'b1;
    order[0] = 2'b01; order[1] = 2'b10; order[2] = 2'b01; order[3] = 2'b10;
    for (int i = 0; i < 4; i++) begin
      get_frame(f, nb, idl, g0, g1, gs);
      check("cont_grant", {30'd0, g1, g0}, {30'd0, order[i]});
      check("cont_data",  {11'd0, f}, (order[i] == 2'b01) ? 32'h00155555 : 32'h000ABCDE);
      check("cont_bits",  nb, 32'd21);
      check("cont_gnt_1cyc", {31'd0, gs}, 32'd0);
      check("cont_count", {28'd0, bus.frames_sent}, i + 1);
      if (i > 0) check("cont_gap", idl, 32'd0);
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;

    // Frame latched at grant even though frame0 changes in the gnt cycle.
    @(negedge clk);
    swap0_en = 1'b1; swap0_val = 21'h000000;
    bus.req0 = 1'b1; bus.frame0 = 21'h1FFFFF;
    get_frame(f, nb, idl, g0, g1, gs);
    bus.req0 = 1'b0; swap0_en = 1'b0;
    check("latch_data",  {11'd0, f}, 32'h001FFFFF);
    check("latch_gnt0",  {31'd0, g0}, 32'd1);
    check("latch_count", {28'd0, bus.frames_sent}, 32'd5);

    // Saturation: frames 6..8 from requester 1, then a 9th request is ignored.
    bus.req1 = 1'b1; bus.frame1 = 21'h0C0003;
    for (int i = 6; i <= 8; i++) begin
      get_frame(f, nb, idl, g0, g1, gs);
      check("sat_data",  {11'd0, f}, 32'h000C0003);
      check("sat_count", {28'd0, bus.frames_sent}, i);
      check("sat_done",  {31'd0, bus.done}, (i == 8) ? 32'd1 : 32'd0);
    end
    saw_sen0 = 1'b0; saw_gnt = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.sen !== 1'b1) saw_sen0 = 1'b1;
      if (bus.gnt1 !== 1'b0) saw_gnt = 1'b1;
    end
    check("sat_no_frame", {31'd0, saw_sen0}, 32'd0);
    check("sat_no_gnt",   {31'd0, saw_gnt},  32'd0);
    check("sat_done_hold",  {31'd0, bus.done}, 32'd1);
    check("sat_count_hold", {28'd0, bus.frames_sent}, 32'd8);
    check("sat_busy",       {31'd0, bus.busy}, 32'd0);

    // Reset between edges clears done at once; then abort frame 3 at bit 10.
    #2 rst = 1'b0; bus.req1 = 1'b0;
    #1 check("async_done", {31'd0, bus.done}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    bus.req0 = 1'b1; bus.frame0 = 21'h0F0F0F;
    get_frame(f, nb, idl, g0, g1, gs);
    get_frame(f, nb, idl, g0, g1, gs);
    check("mid_pre_count", {28'd0, bus.frames_sent}, 32'd2);
    @(negedge clk);
    check("mid_frame3_start", {31'd0, bus.sen}, 32'd0);
    repeat (10) @(negedge clk);
    check("mid_bit10_sen", {31'd0, bus.sen}, 32'd0);
    #2 rst = 1'b0; bus.req0 = 1'b0;
    #1;
    check("mid_async_sen",   {31'd0, bus.sen}, 32'd1);
    check("mid_async_sd",    {31'd0, bus.sd},  32'd0);
    check("mid_async_count", {28'd0, bus.frames_sent}, 32'd0);
    check("mid_async_busy",  {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    bus.req0 = 1'b1; bus.frame0 = 21'h1A2B3C;
    get_frame(f, nb, idl, g0, g1, gs);
    bus.req0 = 1'b0;
    check("post_data",  {11'd0, f}, 32'h001A2B3C);
    check("post_bits",  nb, 32'd21);
    check("post_count", {28'd0, bus.frames_sent}, 32'd1);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
